// File: rtl/axi4_slave_core_bridge_pkg.sv
// -----------------------------------------------------------------------------
// axi4_slave_core_bridge_pkg
// Shared constants for the AXI4 slave -> accelerator core bridge:
//   - AXI burst and response codes
//   - the only supported beat size (8 bytes, AxSIZE = 3)
//   - write / read FSM state encodings
//   - burst_is_err(): decides whether a burst is served as SLVERR with no core access
// Optional feature macro: AXI_WRAP_BURST_EN (WRAP bursts of length 2/4/8/16 allowed)
// -----------------------------------------------------------------------------
package axi4_slave_core_bridge_pkg;

  typedef logic [1:0] axi_burst_t;
  typedef logic [1:0] axi_resp_t;

  localparam axi_burst_t BURST_FIXED = 2'b00;
  localparam axi_burst_t BURST_INCR  = 2'b01;
  localparam axi_burst_t BURST_WRAP  = 2'b10;
  localparam axi_burst_t BURST_RSVD  = 2'b11;

  localparam axi_resp_t  RESP_OKAY   = 2'b00;
  localparam axi_resp_t  RESP_SLVERR = 2'b10;

  localparam logic [2:0] BEAT_SIZE   = 3'd3;

  // write FSM
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  // read FSM
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_HOLD  = 2'd2;
  localparam logic [1:0] R_SEND  = 2'd3;

  // A burst flagged here still consumes/produces all its beats, but never
  // touches the core and is answered with SLVERR.
  function automatic logic burst_is_err(input logic [2:0] size,
                                        input axi_burst_t burst,
                                        input logic [7:0] len);
    logic err;
    err = (size != BEAT_SIZE) || (burst == BURST_RSVD);
    if (burst == BURST_WRAP) begin
`ifdef AXI_WRAP_BURST_EN
      err = err || !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
`else
      err = 1'b1;
`endif
    end
    return err;
  endfunction

endpackage

// File: rtl/axi4_slave_core_bridge_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational next-beat address for 8-byte beats.
//   addr      in  ADDR_WIDTH  current beat address
//   len       in  8           AxLEN of the burst
//   burst     in  2           AxBURST
//   next_addr out ADDR_WIDTH  address of the following beat
// INCR: aligned-down address + 8, wrapping modulo 2^ADDR_WIDTH.
// FIXED: unchanged. WRAP: increments inside a (len+1)*8 byte aligned window;
// only meaningful for len 1/3/7/15, other lengths never reach the core.
// -----------------------------------------------------------------------------
module axi_burst_addr_gen
  import axi4_slave_core_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 20
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  axi_burst_t            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign incr_addr = {addr[ADDR_WIDTH-1:3], 3'b000} + ADDR_WIDTH'(8);
  // len 1/3/7/15 -> window masks 0x0F/0x1F/0x3F/0x7F
  assign wrap_mask = {{(ADDR_WIDTH-7){1'b0}}, len[3:0], 3'b111};

  always_comb begin
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_core_bridge.sv
// -----------------------------------------------------------------------------
// axi4_slave_core_bridge
// AXI4 burst slave front end for the lane-detection accelerator core. Turns
// AW/W/B and AR/R bursts into the core's single-beat write and fixed-latency
// read ports. Read and write paths are fully independent.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   s_aw*, s_w*, s_b*               AXI write address / data / response
//   s_ar*, s_r*                     AXI read address / data
//   core_wr_en/addr/data/strobe     registered write beat to core
//   core_wready                     core can accept a write this cycle
//   core_rd_en/addr, core_rd_data   read request; data valid RD_LATENCY later
// Optional feature macro: AXI_WRAP_BURST_EN (see package)
//
// Write FSM
//   state  | meaning
//   W_IDLE | accepting AW
//   W_DATA | accepting W beats, counting down to the final beat
//   W_RESP | B response held until s_bready
// Read FSM
//   state   | meaning
//   R_IDLE  | accepting AR
//   R_ISSUE | core_rd_en pulse with beat address
//   R_HOLD  | address held for RD_LATENCY cycles, data captured on last one
//   R_SEND  | R beat presented until s_rready
// -----------------------------------------------------------------------------
module axi4_slave_core_bridge
  import axi4_slave_core_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int ID_WIDTH   = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // write address
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  // write data
  input  logic [63:0]           s_wdata,
  input  logic [7:0]            s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  // write response
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // read address
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  // read data
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [63:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  // core side
  output logic                  core_wr_en,
  output logic [ADDR_WIDTH-1:0] core_wr_addr,
  output logic [63:0]           core_wr_data,
  output logic [7:0]            core_wr_strobe,
  input  logic                  core_wready,
  output logic                  core_rd_en,
  output logic [ADDR_WIDTH-1:0] core_rd_addr,
  input  logic [63:0]           core_rd_data
);

  // Keeps both address channels from advertising ready while in reset.
  logic run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // write path
  // ---------------------------------------------------------------------------
  logic [1:0]            w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_next;
  logic [7:0]            w_cnt;
  logic [7:0]            w_len;
  axi_burst_t            w_burst;
  logic                  w_err;
  logic                  w_last_err;
  logic [ID_WIDTH-1:0]   w_id;

  assign s_awready = (w_state == W_IDLE) && run_q;
  assign s_wready  = (w_state == W_DATA) && core_wready;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_aw_addr_gen (
    .addr      (w_addr),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state        <= W_IDLE;
      w_addr         <= '0;
      w_cnt          <= '0;
      w_len          <= '0;
      w_burst        <= BURST_INCR;
      w_err          <= 1'b0;
      w_last_err     <= 1'b0;
      w_id           <= '0;
      s_bid          <= '0;
      s_bresp        <= RESP_OKAY;
      s_bvalid       <= 1'b0;
      core_wr_en     <= 1'b0;
      core_wr_addr   <= '0;
      core_wr_data   <= '0;
      core_wr_strobe <= '0;
    end else begin
      core_wr_en <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (s_awvalid && s_awready) begin
            w_state    <= W_DATA;
            w_id       <= s_awid;
            w_addr     <= (s_awburst == BURST_FIXED) ? s_awaddr
                                                     : {s_awaddr[ADDR_WIDTH-1:3], 3'b000};
            w_cnt      <= s_awlen;
            w_len      <= s_awlen;
            w_burst    <= s_awburst;
            w_err      <= burst_is_err(s_awsize, s_awburst, s_awlen);
            w_last_err <= 1'b0;
          end
        end
        W_DATA: begin
          if (s_wvalid && s_wready) begin
            core_wr_en     <= ~w_err;
            core_wr_addr   <= w_addr;
            core_wr_data   <= s_wdata;
            core_wr_strobe <= s_wstrb;
            w_addr         <= w_next;
            // burst length is set by AWLEN; WLAST is only checked against it
            if (w_cnt == 8'd0) begin
              w_state  <= W_RESP;
              s_bvalid <= 1'b1;
              s_bid    <= w_id;
              s_bresp  <= (w_err || w_last_err || !s_wlast) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              w_cnt <= w_cnt - 8'd1;
              if (s_wlast) w_last_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // read path
  // ---------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_next;
  logic [7:0]            r_cnt;
  logic [7:0]            r_len;
  axi_burst_t            r_burst;
  logic                  r_err;
  logic [1:0]            r_hold;
  logic [ID_WIDTH-1:0]   r_id;

  assign s_arready    = (r_state == R_IDLE) && run_q;
  assign core_rd_en   = (r_state == R_ISSUE) && !r_err;
  // r_addr only moves in R_SEND, so it is stable through ISSUE and HOLD
  assign core_rd_addr = r_addr;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_ar_addr_gen (
    .addr      (r_addr),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (r_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_burst  <= BURST_INCR;
      r_err    <= 1'b0;
      r_hold   <= '0;
      r_id     <= '0;
      s_rid    <= '0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
      s_rlast  <= 1'b0;
      s_rvalid <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_arvalid && s_arready) begin
            r_state <= R_ISSUE;
            r_id    <= s_arid;
            r_addr  <= (s_arburst == BURST_FIXED) ? s_araddr
                                                  : {s_araddr[ADDR_WIDTH-1:3], 3'b000};
            r_cnt   <= s_arlen;
            r_len   <= s_arlen;
            r_burst <= s_arburst;
            r_err   <= burst_is_err(s_arsize, s_arburst, s_arlen);
          end
        end
        R_ISSUE: begin
          r_hold  <= 2'(RD_LATENCY - 1);
          r_state <= R_HOLD;
        end
        R_HOLD: begin
          if (r_hold == 2'd0) begin
            s_rdata  <= r_err ? 64'd0 : core_rd_data;
            s_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
            s_rlast  <= (r_cnt == 8'd0);
            s_rid    <= r_id;
            s_rvalid <= 1'b1;
            r_state  <= R_SEND;
          end else begin
            r_hold <= r_hold - 2'd1;
          end
        end
        R_SEND: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            if (r_cnt == 8'd0) begin
              r_state <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt - 8'd1;
              r_addr  <= r_next;
              r_state <= R_ISSUE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_core_bridge.sv
// -----------------------------------------------------------------------------
// tb_axi4_slave_core_bridge
// Directed bench for axi4_slave_core_bridge: write bursts with core stalls,
// read bursts against a registered BRAM model, error bursts and reset abort.
// Honours AXI_WRAP_BURST_EN for the WRAP write expectation.
// -----------------------------------------------------------------------------
module tb_axi4_slave_core_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s_awid;
  logic [19:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_awvalid;
  logic        s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast;
  logic        s_wvalid;
  logic        s_wready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [3:0]  s_arid;
  logic [19:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arvalid;
  logic        s_arready;
  logic [3:0]  s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready;
  logic        core_wr_en;
  logic [19:0] core_wr_addr;
  logic [63:0] core_wr_data;
  logic [7:0]  core_wr_strobe;
  logic        core_wready;
  logic        core_rd_en;
  logic [19:0] core_rd_addr;
  logic [63:0] core_rd_data = 64'd0;

  axi4_slave_core_bridge #(.ADDR_WIDTH(20), .ID_WIDTH(4), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_wr_strobe(core_wr_strobe), .core_wready(core_wready),
    .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bram(input logic [19:0] a);
    return {12'hCA5, a, 12'h0F0, a};
  endfunction

  function automatic logic [63:0] wdat(input int i);
    return {32'hD00D_0000, 32'(i)} ^ 64'h0000_0000_1234_0000;
  endfunction

  // core-side observation
  logic [19:0] wl_addr[$];
  logic [63:0] wl_data[$];
  logic [7:0]  wl_strb[$];
  logic [19:0] rl_addr[$];
  logic [63:0] rb_data[$];
  logic [1:0]  rb_resp[$];
  logic        rb_last[$];
  logic [3:0]  rb_id[$];

  always @(negedge clk) begin
    if (core_wr_en) begin
      wl_addr.push_back(core_wr_addr);
      wl_data.push_back(core_wr_data);
      wl_strb.push_back(core_wr_strobe);
    end
    if (core_rd_en) rl_addr.push_back(core_rd_addr);
  end

  // BRAM with one cycle of read latency
  always @(posedge clk) begin
    if (core_rd_en) core_rd_data <= bram(core_rd_addr);
  end

  task automatic ar_hs(input logic [3:0] id, input logic [19:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    t = 0;
    while (!s_arready && t < 50) begin
      @(negedge clk); t++;
    end
    check("ar handshake", 64'(s_arready), 64'd1);
    @(negedge clk);
    s_arvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [19:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input bit stall, input bit bad_last,
                           output logic [1:0] resp, output logic [3:0] bid);
    int t;
    int n;
    wl_addr.delete(); wl_data.delete(); wl_strb.delete();
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    t = 0;
    while (!s_awready && t < 50) begin
      @(negedge clk); t++;
    end
    check("aw handshake", 64'(s_awready), 64'd1);
    @(negedge clk);
    s_awvalid = 1'b0;
    n = 0;
    for (int i = 0; i <= int'(len); i++) begin
      s_wvalid = 1'b1;
      s_wdata  = wdat(i);
      s_wstrb  = 8'hFF;
      s_wlast  = (i == int'(len)) ^ bad_last;
      t = 0;
      forever begin
        core_wready = !(stall && n >= 2 && n <= 5);
        #1;
        if (!core_wready) check("wready stalled", 64'(s_wready), 64'd0);
        if (s_wready || t >= 50) break;
        @(negedge clk); n++; t++;
      end
      check("w handshake", 64'(s_wready), 64'd1);
      @(negedge clk); n++;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0; core_wready = 1'b1;
    s_bready = 1'b1;
    t = 0;
    while (!s_bvalid && t < 50) begin
      @(negedge clk); t++;
    end
    check("bvalid", 64'(s_bvalid), 64'd1);
    resp = s_bresp;
    bid  = s_bid;
    @(negedge clk);
    check("bvalid cleared", 64'(s_bvalid), 64'd0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [19:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int t;
    bit done;
    rl_addr.delete(); rb_data.delete(); rb_resp.delete(); rb_last.delete(); rb_id.delete();
    ar_hs(id, addr, len, size, burst);
    t = 0;
    done = 1'b0;
    while (!done && t < 20000) begin
      s_rready = toggle ? (t % 2 == 1) : 1'b1;
      if (s_rvalid && s_rready) begin
        rb_data.push_back(s_rdata);
        rb_resp.push_back(s_rresp);
        rb_last.push_back(s_rlast);
        rb_id.push_back(s_rid);
        if (s_rlast) done = 1'b1;
      end
      @(negedge clk); t++;
    end
    s_rready = 1'b0;
    check("read burst done", 64'(done), 64'd1);
  endtask

  logic [1:0] resp;
  logic [3:0] bid;

  initial begin
    rst_n = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd3; s_awburst = 2'b01; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd3; s_arburst = 2'b01; s_arvalid = 1'b0;
    s_rready = 1'b0; core_wready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst awready", 64'(s_awready), 64'd0);
    check("rst arready", 64'(s_arready), 64'd0);
    check("rst wready",  64'(s_wready),  64'd0);
    check("rst bvalid",  64'(s_bvalid),  64'd0);
    check("rst rvalid",  64'(s_rvalid),  64'd0);
    check("rst wr_en",   64'(core_wr_en), 64'd0);
    check("rst rd_en",   64'(core_rd_en), 64'd0);
    check("rst bresp",   64'(s_bresp),   64'd0);
    check("rst rresp",   64'(s_rresp),   64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle awready", 64'(s_awready), 64'd1);
    check("idle arready", 64'(s_arready), 64'd1);

    // INCR write, 4 beats
    axi_write(4'h3, 20'h0, 8'd3, 3'd3, 2'b01, 1'b0, 1'b0, resp, bid);
    check("incr nwr", 64'(wl_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("incr addr", 64'(wl_addr[i]), 64'(i * 8));
      check("incr data", wl_data[i], wdat(i));
      check("incr strb", 64'(wl_strb[i]), 64'hFF);
    end
    check("incr bresp", 64'(resp), 64'd0);
    check("incr bid", 64'(bid), 64'h3);

    // same burst with core_wready low for cycles 2..5
    axi_write(4'h7, 20'h0, 8'd3, 3'd3, 2'b01, 1'b1, 1'b0, resp, bid);
    check("stall nwr", 64'(wl_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("stall addr", 64'(wl_addr[i]), 64'(i * 8));
      check("stall data", wl_data[i], wdat(i));
    end
    check("stall bresp", 64'(resp), 64'd0);
    check("stall bid", 64'(bid), 64'h7);

    // AWSIZE 2: beats drained, no core writes
    axi_write(4'h1, 20'h100, 8'd1, 3'd2, 2'b01, 1'b0, 1'b0, resp, bid);
    check("size2 nwr", 64'(wl_addr.size()), 64'd0);
    check("size2 bresp", 64'(resp), 64'd2);

    // WLAST on the wrong beats
    axi_write(4'h2, 20'h200, 8'd1, 3'd3, 2'b01, 1'b0, 1'b1, resp, bid);
    check("wlast nwr", 64'(wl_addr.size()), 64'd2);
    check("wlast bresp", 64'(resp), 64'd2);

    // WRAP len 4 starting at 0x18
    axi_write(4'h4, 20'h18, 8'd3, 3'd3, 2'b10, 1'b0, 1'b0, resp, bid);
`ifdef AXI_WRAP_BURST_EN
    check("wrap nwr", 64'(wl_addr.size()), 64'd4);
    check("wrap addr0", 64'(wl_addr[0]), 64'h18);
    check("wrap addr1", 64'(wl_addr[1]), 64'h00);
    check("wrap addr2", 64'(wl_addr[2]), 64'h08);
    check("wrap addr3", 64'(wl_addr[3]), 64'h10);
    check("wrap bresp", 64'(resp), 64'd0);
`else
    check("wrap nwr", 64'(wl_addr.size()), 64'd0);
    check("wrap bresp", 64'(resp), 64'd2);
`endif

    // FIXED read, 2 beats
    axi_read(4'h5, 20'h6_0808, 8'd1, 3'd3, 2'b00, 1'b0);
    check("fixed nrd", 64'(rl_addr.size()), 64'd2);
    check("fixed nbeat", 64'(rb_data.size()), 64'd2);
    for (int i = 0; i < 2; i++) begin
      check("fixed addr", 64'(rl_addr[i]), 64'h6_0808);
      check("fixed data", rb_data[i], bram(20'h6_0808));
      check("fixed rresp", 64'(rb_resp[i]), 64'd0);
      check("fixed rid", 64'(rb_id[i]), 64'h5);
    end
    check("fixed last0", 64'(rb_last[0]), 64'd0);
    check("fixed last1", 64'(rb_last[1]), 64'd1);

    // INCR read, 256 beats, rready toggling
    axi_read(4'h9, 20'h6_0000, 8'd255, 3'd3, 2'b01, 1'b1);
    check("long nrd", 64'(rl_addr.size()), 64'd256);
    check("long nbeat", 64'(rb_data.size()), 64'd256);
    for (int i = 0; i < 256; i++) begin
      logic [19:0] ea;
      ea = 20'h6_0000 + 20'(i * 8);
      check("long addr", 64'(rl_addr[i]), 64'(ea));
      check("long data", rb_data[i], bram(ea));
      check("long last", 64'(rb_last[i]), 64'(i == 255));
    end
    check("long rresp", 64'(rb_resp[255]), 64'd0);

    // ARSIZE 2: no core reads, zero data, SLVERR every beat
    axi_read(4'h6, 20'h300, 8'd1, 3'd2, 2'b01, 1'b0);
    check("rsize nrd", 64'(rl_addr.size()), 64'd0);
    check("rsize nbeat", 64'(rb_data.size()), 64'd2);
    for (int i = 0; i < 2; i++) begin
      check("rsize data", rb_data[i], 64'd0);
      check("rsize rresp", 64'(rb_resp[i]), 64'd2);
    end

    // reserved burst type
    axi_read(4'h8, 20'h400, 8'd0, 3'd3, 2'b11, 1'b0);
    check("rsvd nrd", 64'(rl_addr.size()), 64'd0);
    check("rsvd rresp", 64'(rb_resp[0]), 64'd2);

    // reset in the middle of a read burst
    s_rready = 1'b0;
    ar_hs(4'hA, 20'h100, 8'd3, 3'd3, 2'b01);
    begin
      int t;
      t = 0;
      while (!s_rvalid && t < 50) begin
        @(negedge clk); t++;
      end
    end
    check("abort rvalid before", 64'(s_rvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort rvalid", 64'(s_rvalid), 64'd0);
    check("abort rd_en", 64'(core_rd_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(4'hB, 20'h200, 8'd0, 3'd3, 2'b01, 1'b0);
    check("post nbeat", 64'(rb_data.size()), 64'd1);
    check("post data", rb_data[0], bram(20'h200));
    check("post rresp", 64'(rb_resp[0]), 64'd0);
    check("post rid", 64'(rb_id[0]), 64'hB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
